// File: rtl/memory_bank_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memory_bank_array_pkg
//  Desc     : Shared types and helpers for the banked memory array.
//             Optional feature macro: MEMORY_BANK_ARRAY_STATS_EN
//  Revision : 1.0 - initial release
// ============================================================================
package memory_bank_array_pkg;

  // Default build configuration; the response entry type is sized from it,
  // so the top-level defaults of NUM_BANKS/DATA_WIDTH must match these.
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_DATA_WIDTH = 64;

  // Bank-select field width; a single bank still keeps a 1-bit field.
  function automatic int calc_bank_bits(input int num_banks);
    return (num_banks <= 1) ? 1 : $clog2(num_banks);
  endfunction

  localparam int DEF_BANK_BITS = calc_bank_bits(DEF_NUM_BANKS);
  localparam int STRB_WIDTH    = DEF_DATA_WIDTH / 8;

  // One buffered response.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      is_write;
    logic [DEF_BANK_BITS-1:0]  bank;
  } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/memory_bank_slice.sv
`default_nettype none
// ============================================================================
//  Module   : memory_bank_slice
//  Desc     : One memory bank: byte-strobed write, registered read and an
//             optional saturating access counter.
//             Optional feature macro: MEMORY_BANK_ARRAY_STATS_EN
//  Revision : 1.0 - initial release
// ============================================================================
module memory_bank_slice #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_sel,
  input  logic                     i_we,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [DATA_WIDTH/8-1:0]  i_wstrb,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic [COUNT_WIDTH-1:0]   o_count
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;
  localparam int c_STRB  = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-strobed write; storage is deliberately never reset.
  always_ff @(posedge clk) begin
    if (i_sel && i_we) begin
      for (int b = 0; b < c_STRB; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; holds its value until the next read of this bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_sel && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

`ifdef MEMORY_BANK_ARRAY_STATS_EN
  logic [COUNT_WIDTH-1:0] r_count;

  // Saturating count of every accepted access to this bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_sel && (r_count != {COUNT_WIDTH{1'b1}})) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;
`else
  assign o_count = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/memory_bank_array.sv
`default_nettype none
// ============================================================================
//  Module   : memory_bank_array
//  Desc     : NUM_BANKS interleaved banks behind a valid/ready request port
//             and an in-order valid/ready response port with a credit-based
//             response FIFO.
//             Optional feature macro: MEMORY_BANK_ARRAY_STATS_EN
//  Revision : 1.0 - initial release
// ============================================================================
module memory_bank_array
  import memory_bank_array_pkg::*;
#(
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH   = 2,
  parameter int COUNT_WIDTH = 16,
  localparam int BANK_BITS  = calc_bank_bits(NUM_BANKS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_req_we,
  input  logic [ADDR_WIDTH+BANK_BITS-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0]           i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]         i_req_wstrb,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [DATA_WIDTH-1:0]           o_rsp_rdata,
  output logic                            o_rsp_is_write,
  output logic [BANK_BITS-1:0]            o_rsp_bank,
  input  logic [BANK_BITS-1:0]            i_stat_bank,
  output logic [COUNT_WIDTH-1:0]          o_stat_count
);

  localparam int                 c_PTR_W    = $clog2(RSP_DEPTH);
  localparam int                 c_CNT_W    = $clog2(RSP_DEPTH + 1);
  localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(RSP_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(RSP_DEPTH - 1);

  logic                                   w_acc;
  logic [BANK_BITS-1:0]                   w_bank;
  logic [ADDR_WIDTH-1:0]                  w_word;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]   w_rd;
  logic [NUM_BANKS-1:0][COUNT_WIDTH-1:0]  w_cnt;
  logic [c_CNT_W:0]                       w_occ;
  logic                                   w_push;
  logic                                   w_pop;
  rsp_entry_t                             w_push_entry;
  rsp_entry_t                             w_head;

  logic                  r_s1_valid;
  logic                  r_s1_we;
  logic [BANK_BITS-1:0]  r_s1_bank;
  rsp_entry_t            r_fifo [RSP_DEPTH];
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Credit: S1 counts as an occupied FIFO slot, so the FIFO can never overflow.
  assign w_occ       = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_s1_valid};
  assign o_req_ready = (w_occ < c_DEPTH);
  assign w_acc       = i_req_valid && o_req_ready;

  // Low address bits pick the bank, the rest pick the word inside it.
  assign w_word = i_req_addr[ADDR_WIDTH+BANK_BITS-1 -: ADDR_WIDTH];

  if (NUM_BANKS == 1) begin : g_single_bank
    logic w_bank_unused;
    assign w_bank        = '0;
    assign w_bank_unused = i_req_addr[0];
  end else begin : g_multi_bank
    assign w_bank = i_req_addr[BANK_BITS-1:0];
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    memory_bank_slice #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_sel   (w_acc && (w_bank == BANK_BITS'(g))),
      .i_we    (i_req_we),
      .i_addr  (w_word),
      .i_wdata (i_req_wdata),
      .i_wstrb (i_req_wstrb),
      .o_rdata (w_rd[g]),
      .o_count (w_cnt[g])
    );
  end

  // S1 tracks the accepted request while its read data is registered in the bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_bank  <= '0;
    end else begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_we   <= i_req_we;
        r_s1_bank <= w_bank;
      end
    end
  end

  // Build the FIFO entry from S1; writes always report zero data.
  always_comb begin
    w_push_entry          = '0;
    w_push_entry.is_write = r_s1_we;
    w_push_entry.bank     = r_s1_bank;
    if (!r_s1_we) begin
      w_push_entry.rdata = w_rd[r_s1_bank];
    end
  end

  assign w_push = r_s1_valid;
  assign w_pop  = o_rsp_valid && i_rsp_ready;

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy; reset drops everything buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response fields read as zero whenever nothing is being offered.
  assign w_head         = r_fifo[r_rd_ptr];
  assign o_rsp_valid    = (r_count != '0);
  assign o_rsp_rdata    = o_rsp_valid ? w_head.rdata    : '0;
  assign o_rsp_is_write = o_rsp_valid ? w_head.is_write : 1'b0;
  assign o_rsp_bank     = o_rsp_valid ? w_head.bank     : '0;

`ifdef MEMORY_BANK_ARRAY_STATS_EN
  logic [BANK_BITS-1:0]   w_stat_sel;
  logic [COUNT_WIDTH-1:0] r_stat_count;

  assign w_stat_sel = (NUM_BANKS == 1) ? '0 : i_stat_bank;

  // One-cycle registered statistics readout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_count <= '0;
    end else begin
      r_stat_count <= w_cnt[w_stat_sel];
    end
  end

  assign o_stat_count = r_stat_count;
`else
  logic w_stat_unused;
  assign w_stat_unused = ^{i_stat_bank, w_cnt};
  assign o_stat_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_bank_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_bank_array
//  Desc     : Self-checking bench for memory_bank_array with a transaction
//             level reference model and directed literal checks.
//             Optional feature macro: MEMORY_BANK_ARRAY_STATS_EN
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bank_array;

  localparam int NB = 4;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int RD = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [7:0]    req_wstrb = '0;
  logic          rsp_ready = 1'b1;
  logic [1:0]    stat_bank = 2'd2;

  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_is_write;
  logic [1:0]    rsp_bank;
  logic [CW-1:0] stat_count;

  always #5 clk = ~clk;

  memory_bank_array #(
    .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(RD), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_is_write(rsp_is_write), .o_rsp_bank(rsp_bank),
    .i_stat_bank(stat_bank), .o_stat_count(stat_count)
  );

`ifdef MEMORY_BANK_ARRAY_STATS_EN
  logic          s_req_ready, s_rsp_valid, s_rsp_is_write;
  logic [DW-1:0] s_rsp_rdata;
  logic [1:0]    s_rsp_bank;
  logic [1:0]    s_stat_count;

  memory_bank_array #(
    .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(RD), .COUNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(s_req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_rsp_valid(s_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(s_rsp_rdata),
    .o_rsp_is_write(s_rsp_is_write), .o_rsp_bank(s_rsp_bank),
    .i_stat_bank(stat_bank), .o_stat_count(s_stat_count)
  );
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [63:0] rdata;
    logic        is_write;
    logic [1:0]  bank;
    int          vis;   // edge after which the response is offered
  } exp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        is_write;
    logic [1:0]  bank;
  } got_t;

  exp_t        q[$];
  got_t        got[$];
  logic [63:0] mem_m [int];
  int          cnt_m [NB];
  logic [63:0] stat_m = '0;
  int          edge_n = 0;
  int          n_acc = 0;
  bit          live = 0;
  bit          acc_flag = 0;

  always @(posedge clk) begin
    bit          rdy;
    bit          vld;
    exp_t        e;
    int          a;
    logic [63:0] w;
    edge_n++;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < NB; i++) cnt_m[i] = 0;
      stat_m   = '0;
      acc_flag = 0;
      live     = 1;
    end else begin
      rdy    = (q.size() < RD);
      vld    = (q.size() > 0) && (q[0].vis <= edge_n - 1);
      stat_m = 64'(cnt_m[stat_bank]);
      if (vld && rsp_ready) void'(q.pop_front());
      acc_flag = req_valid && rdy;
      if (acc_flag) begin
        n_acc++;
        a = int'(req_addr);
        if (cnt_m[req_addr[1:0]] < 65535) cnt_m[req_addr[1:0]]++;
        e.bank     = req_addr[1:0];
        e.is_write = req_we;
        e.vis      = edge_n + 1;
        w = mem_m.exists(a) ? mem_m[a] : 64'd0;
        if (req_we) begin
          for (int b = 0; b < 8; b++)
            if (req_wstrb[b]) w[b*8 +: 8] = req_wdata[b*8 +: 8];
          mem_m[a] = w;
          e.rdata  = '0;
        end else begin
          e.rdata = w;
        end
        q.push_back(e);
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    bit vld;
    if (live) begin
      vld = (q.size() > 0) && (q[0].vis <= edge_n);
      chk("req_ready", 64'(req_ready), 64'(q.size() < RD));
      chk("rsp_valid", 64'(rsp_valid), 64'(vld));
      if (vld && rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, q[0].rdata);
        chk("rsp_is_write", 64'(rsp_is_write), 64'(q[0].is_write));
        chk("rsp_bank", 64'(rsp_bank), 64'(q[0].bank));
      end
`ifdef MEMORY_BANK_ARRAY_STATS_EN
      chk("stat_count", 64'(stat_count), stat_m);
`else
      chk("stat_count", 64'(stat_count), 64'd0);
`endif
      if (rsp_valid && rsp_ready)
        got.push_back('{rdata: rsp_rdata, is_write: rsp_is_write, bank: rsp_bank});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input logic we, input logic [9:0] addr,
                        input logic [63:0] wd, input logic [7:0] ws);
    int k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!acc_flag && k < 60);
    if (!acc_flag) chk("req_accept_timeout", 64'(k), 64'd0);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_is_write", 64'(rsp_is_write), 64'd0);
    chk("rst_rsp_bank", 64'(rsp_bank), 64'd0);
    chk("rst_stat_count", 64'(stat_count), 64'd0);
    @(posedge clk);
    #1;

    // Full write then read of addr 0x05 (bank 1)
    got.delete();
    do_req(1'b1, 10'h005, 64'h1122334455667788, 8'hFF);
    do_req(1'b0, 10'h005, 64'd0, 8'h00);
    drain();
    chk("t1_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("t1_wr_rdata", got[0].rdata, 64'd0);
      chk("t1_wr_is_write", 64'(got[0].is_write), 64'd1);
      chk("t1_wr_bank", 64'(got[0].bank), 64'd1);
      chk("t1_rd_rdata", got[1].rdata, 64'h1122334455667788);
      chk("t1_rd_is_write", 64'(got[1].is_write), 64'd0);
      chk("t1_rd_bank", 64'(got[1].bank), 64'd1);
    end

    // Partial strobe on addr 0x0A (bank 2)
    got.delete();
    do_req(1'b1, 10'h00A, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    do_req(1'b1, 10'h00A, 64'd0, 8'h0F);
    do_req(1'b0, 10'h00A, 64'd0, 8'h00);
    drain();
    chk("t2_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) chk("t2_rdata", got[2].rdata, 64'hFFFFFFFF00000000);

    // Backpressure: only two requests fit while responses are held
    got.delete();
    rsp_ready = 1'b0;
    acc0 = n_acc;
    do_req(1'b0, 10'h005, 64'd0, 8'h00);
    do_req(1'b0, 10'h00A, 64'd0, 8'h00);
    fork
      do_req(1'b0, 10'h005, 64'd0, 8'h00);
      begin
        repeat (3) @(negedge clk);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_accepts", 64'(n_acc - acc0), 64'd2);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_rdata0", got[0].rdata, 64'h1122334455667788);
      chk("bp_rdata1", got[1].rdata, 64'hFFFFFFFF00000000);
      chk("bp_rdata2", got[2].rdata, 64'h1122334455667788);
    end

    // Streaming across all banks
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 10'(16 + i), 64'h0123456789AB0000 + 64'(i), 8'hFF);
    drain();
    got.delete();
    acc0 = n_acc;
    for (int i = 0; i < 16; i++)
      do_req(1'b0, 10'(16 + i), 64'd0, 8'h00);
    drain();
    chk("st_accepts", 64'(n_acc - acc0), 64'd16);
    chk("st_count", 64'(got.size()), 64'd16);
    if (got.size() == 16) begin
      chk("st_rdata0", got[0].rdata, 64'h0123456789AB0000);
      chk("st_rdata15", got[15].rdata, 64'h0123456789AB000F);
      chk("st_bank6", 64'(got[6].bank), 64'd2);
    end

    // Reset with two buffered responses
    got.delete();
    rsp_ready = 1'b0;
    do_req(1'b0, 10'h005, 64'd0, 8'h00);
    do_req(1'b0, 10'h00A, 64'd0, 8'h00);
    @(posedge clk);
    #1;
    chk("mr_buffered", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    do_req(1'b0, 10'h005, 64'd0, 8'h00);
    drain();
    chk("mr_count", 64'(got.size()), 64'd1);
    if (got.size() == 1) chk("mr_rdata", got[0].rdata, 64'h1122334455667788);

`ifdef MEMORY_BANK_ARRAY_STATS_EN
    // Statistics: three then five accesses to bank 2 since the last reset
    stat_bank = 2'd2;
    for (int i = 0; i < 3; i++) do_req(1'b0, 10'h00A, 64'd0, 8'h00);
    drain();
    chk("stat3", 64'(stat_count), 64'd3);
    chk("stat3_sat", 64'(s_stat_count), 64'd3);
    for (int i = 0; i < 2; i++) do_req(1'b0, 10'h00A, 64'd0, 8'h00);
    drain();
    chk("stat5", 64'(stat_count), 64'd5);
    chk("stat5_sat", 64'(s_stat_count), 64'd3);
    stat_bank = 2'd1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stat_bank1", 64'(stat_count), 64'd1);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
